// File: rtl/fall_through_small_fifo_pkg.sv
// ============================================================================
// Module : fall_through_small_fifo_pkg
// Brief  : Shared sizing helper for the fall-through FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fall_through_small_fifo_pkg;

    // Ceiling log2, used by instantiators to pick MAX_DEPTH_BITS from an entry count.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fall_through_small_fifo.sv
// ============================================================================
// Module : fall_through_small_fifo
// Brief  : Small synchronous first-word-fall-through FIFO with status flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fall_through_small_fifo
    import fall_through_small_fifo_pkg::*;
#(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
    localparam int CW        = MAX_DEPTH_BITS + 1;

    localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]             CNT_FULL = CW'(MAX_DEPTH);
    localparam logic [CW-1:0]             CNT_NF   = CW'(MAX_DEPTH - 1);
    localparam logic [CW-1:0]             CNT_PF   = CW'(PROG_FULL_THRESHOLD);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          mem [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q,  count_d;
    logic                      wr_acc;
    logic                      rd_acc;

    always_comb begin
        wr_acc   = wr_en & ~full;
        rd_acc   = rd_en & ~empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        dout        = mem[rd_ptr_q];
        full        = (count_q == CNT_FULL);
        nearly_full = (count_q >= CNT_NF);
        prog_full   = (count_q >= CNT_PF);
        empty       = (count_q == '0);
    end

endmodule

`default_nettype wire

// File: tb/tb_fall_through_small_fifo.sv
// ============================================================================
// Module : tb_fall_through_small_fifo
// Brief  : Scoreboard bench for the fall-through FIFO (WIDTH=8, depth 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fall_through_small_fifo;

    localparam int W  = 8;
    localparam int DB = 2;
    localparam int D  = 4;
    localparam int PF = 3;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         nearly_full;
    logic         prog_full;
    logic         empty;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb [$];

    fall_through_small_fifo #(
        .WIDTH          (W),
        .MAX_DEPTH_BITS (DB)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .nearly_full (nearly_full),
        .prog_full   (prog_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_state(input string where);
        int n;
        n = sb.size();
        check({where, ":empty"},       32'(empty),       32'(n == 0));
        check({where, ":full"},        32'(full),        32'(n == D));
        check({where, ":nearly_full"}, 32'(nearly_full), 32'(n >= D - 1));
        check({where, ":prog_full"},   32'(prog_full),   32'(n >= PF));
        if (n > 0) check({where, ":head"}, 32'(dout), 32'(sb[0]));
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic drive(input logic w, input logic r, input logic [W-1:0] d, input string where);
        logic m_wr;
        logic m_rd;
        logic [W-1:0] exp;
        wr_en = w;
        rd_en = r;
        din   = d;
        m_wr  = w && (sb.size() != D);
        m_rd  = r && (sb.size() != 0);
        if (m_rd) begin
            exp = sb.pop_front();
            check({where, ":pop"}, 32'(dout), 32'(exp));
        end
        if (m_wr) sb.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(where);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        check_state("reset");
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        @(posedge clk);
        #1;
        do_reset();
        drive(1'b0, 1'b0, 8'h00, "idle");

        check("clog2_66", fall_through_small_fifo_pkg::clog2(66), 32'd7);

        drive(1'b1, 1'b0, 8'hA5, "fwft_wr");
        check("fwft_dout", 32'(dout), 32'hA5);
        drive(1'b0, 1'b1, 8'h00, "fwft_rd");

        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, W'(i), "fill");
        check("full_after_fill", 32'(full), 32'd1);
        drive(1'b1, 1'b0, 8'h05, "overflow");
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00, "drain");
        drive(1'b0, 1'b1, 8'h00, "underflow");

        drive(1'b1, 1'b0, 8'h64, "pre_ramp");
        drive(1'b1, 1'b0, 8'h65, "pre_ramp");
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, W'(i), "ramp");
        check("ramp_count2", 32'(sb.size()), 32'd2);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 8'h00, "ramp_drain");

        drive(1'b1, 1'b1, 8'h33, "rw_empty");
        check("rw_empty_dout", 32'(dout), 32'h33);
        drive(1'b0, 1'b1, 8'h00, "rw_empty_drain");

        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, W'(8'h40 + i), "fill2");
        drive(1'b1, 1'b1, 8'h99, "rw_full");
        check("rw_full_nf", 32'(nearly_full), 32'd1);
        check("rw_full_notfull", 32'(full), 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h00, "rw_full_drain");

        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'(8'h50 + i), "pre_reset");
        do_reset();
        check("mid_reset_empty", 32'(empty), 32'd1);
        drive(1'b1, 1'b0, 8'h77, "post_reset_wr");
        check("post_reset_dout", 32'(dout), 32'h77);
        drive(1'b1, 1'b0, 8'h78, "post_reset_wr");
        drive(1'b0, 1'b1, 8'h00, "post_reset_rd");
        drive(1'b0, 1'b1, 8'h00, "post_reset_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
